// File: rtl/apb_uart_tx_slave_if.sv
// ---------------------------------------------------------------------------
// apb_uart_tx_slave_if
// APB3 bus bundle between the requester (master) and the UART TX completer.
//
// Signals
//    pselx    completer select
//    penable  access phase marker
//    pwrite   1 = write, 0 = read
//    paddr    byte address (register index lives in paddr[4:2])
//    pwdata   write data
//    prdata   read data, valid during a read access phase
//    pready   transfer complete (always in the first access cycle)
//    pslverr  transfer error
// ---------------------------------------------------------------------------
interface apb_uart_tx_slave_if #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32
);

   logic                  pselx;
   logic                  penable;
   logic                  pwrite;
   logic [ADDR_WIDTH-1:0] paddr;
   logic [DATA_WIDTH-1:0] pwdata;
   logic [DATA_WIDTH-1:0] prdata;
   logic                  pready;
   logic                  pslverr;

   modport master (
      output pselx,
      output penable,
      output pwrite,
      output paddr,
      output pwdata,
      input  prdata,
      input  pready,
      input  pslverr
   );

   modport slave (
      input  pselx,
      input  penable,
      input  pwrite,
      input  paddr,
      input  pwdata,
      output prdata,
      output pready,
      output pslverr
   );

endinterface

// File: rtl/apb_uart_tx_slave.sv
// ---------------------------------------------------------------------------
// apb_uart_tx_slave
// APB3 completer with a 16550-style register map and a transmit-only UART.
// Bytes written to THR are queued in a TX FIFO and serialised onto tx_o.
// A level interrupt (event_o) reports "transmit holding register empty".
// There is no receive path; RBR and MSR read as zero.
//
// Ports
//    pclk     APB clock, all state changes on its rising edge
//    preset   asynchronous active-low reset
//    apb      APB3 completer bus (slave modport of apb_uart_tx_slave_if)
//    tx_o     UART serial output, idles high
//    event_o  THRE interrupt, level, registered (one cycle behind THRE)
//
// Register map (index = paddr[4:2], data in bits [7:0])
//    0  THR (W) / RBR (R, 0)      or DLL when LCR[7]=1
//    1  IER                       or DLM when LCR[7]=1
//    2  IIR (R) / FCR (W, bit 2 flushes the TX FIFO)
//    3  LCR   4  MCR   5  LSR (R)   6  MSR (R, 0)   7  SCR
// ---------------------------------------------------------------------------
module apb_uart_tx_slave #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                 pclk,
   input  logic                 preset,
   apb_uart_tx_slave_if.slave   apb,
   output logic                 tx_o,
   output logic                 event_o
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } tx_state_t;

   // ---------------------------------------------------------------------
   // Register file
   // ---------------------------------------------------------------------
   logic [7:0] ier;
   logic [7:0] lcr;
   logic [7:0] mcr;
   logic [7:0] scr;
   logic [7:0] dll;
   logic [7:0] dlm;

   // ---------------------------------------------------------------------
   // TX FIFO storage; pointers carry one extra wrap bit so full and empty
   // can be told apart without a separate counter.
   // ---------------------------------------------------------------------
   logic [7:0]     fifo_mem [FIFO_DEPTH];
   logic [PTR_W:0] wr_ptr;
   logic [PTR_W:0] rd_ptr;
   logic           fifo_empty;
   logic           fifo_full;
   logic [7:0]     fifo_rd_data;

   // ---------------------------------------------------------------------
   // Transmitter state
   // ---------------------------------------------------------------------
   tx_state_t   state;
   logic        tx_reg;
   logic [19:0] bit_timer;
   logic [7:0]  shift_reg;
   logic [2:0]  bit_cnt;
   logic        stop_cnt;
   logic [2:0]  f_last_bit;
   logic        f_stop2;
   logic        f_par_en;
   logic        f_par_bit;
   logic        event_q;

   // ---------------------------------------------------------------------
   // Bus decode
   // ---------------------------------------------------------------------
   logic       access;
   logic       addr_err;
   logic [2:0] reg_idx;
   logic       wr_ok;
   logic       dlab;
   logic [7:0] wdata8;
   logic       thr_wr;
   logic       push;
   logic       flush;
   logic [7:0] rdata8;
   logic       thre;
   logic       temt;
   logic [7:0] lsr;

   // ---------------------------------------------------------------------
   // Baud / frame helpers
   // ---------------------------------------------------------------------
   logic [15:0] divisor;
   logic        d_nz;
   logic [19:0] reload;
   logic        bit_done;
   logic        last_stop;
   logic        fsm_pop;
   logic [7:0]  data_mask;
   logic [7:0]  masked_data;
   logic [2:0]  new_last_bit;
   logic        new_par_bit;

   // Address bits that carry no register meaning (byte lanes, upper data).
   logic unused_bits;
   assign unused_bits = ^{apb.paddr[1:0], apb.pwdata[DATA_WIDTH-1:8]};

   assign access   = apb.pselx & apb.penable;
   assign addr_err = |apb.paddr[ADDR_WIDTH-1:5];
   assign reg_idx  = apb.paddr[4:2];
   assign wdata8   = apb.pwdata[7:0];
   assign dlab     = lcr[7];
   assign wr_ok    = access & apb.pwrite & ~addr_err;

   // A THR write that finds the FIFO full is dropped and flagged as an error.
   assign thr_wr = wr_ok & (reg_idx == 3'd0) & ~dlab;
   assign push   = thr_wr & ~fifo_full;
   assign flush  = wr_ok & (reg_idx == 3'd2) & apb.pwdata[2];

   assign fifo_empty   = (wr_ptr == rd_ptr);
   assign fifo_full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                         (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign fifo_rd_data = fifo_mem[rd_ptr[PTR_W-1:0]];

   assign thre = fifo_empty;
   assign temt = fifo_empty & (state == ST_IDLE);
   assign lsr  = {1'b0, temt, thre, 5'b0};

   assign apb.pready  = access;
   assign apb.pslverr = access & (addr_err |
                        (apb.pwrite & (reg_idx == 3'd0) & ~dlab & fifo_full));
   assign apb.prdata  = (access & ~apb.pwrite & ~addr_err) ?
                        {{(DATA_WIDTH-8){1'b0}}, rdata8} : '0;

   // Break forces the line low without disturbing the frame sequencer.
   assign tx_o    = tx_reg & ~lcr[6];
   assign event_o = event_q;

   // The bit timer counts 16*D-1 down to 0, so each bit lasts 16*D cycles.
   assign divisor   = {dlm, dll};
   assign d_nz      = |divisor;
   assign reload    = {divisor, 4'b0000} - 20'd1;
   assign bit_done  = d_nz & (bit_timer == 20'd0);
   assign last_stop = ~f_stop2 | stop_cnt;

   // A new frame starts from IDLE, or straight out of the final stop bit so
   // consecutive frames have no idle gap between them.
   assign fsm_pop = ~fifo_empty & d_nz &
                    ((state == ST_IDLE) |
                     ((state == ST_STOP) & bit_done & last_stop));

   // Frame format is captured from LCR at the moment the byte is popped.
   assign new_last_bit = {1'b0, lcr[1:0]} + 3'd4;
   assign data_mask    = 8'hFF >> (2'd3 - lcr[1:0]);
   assign masked_data  = fifo_rd_data & data_mask;
   assign new_par_bit  = lcr[4] ? (^masked_data) : ~(^masked_data);

   // Read multiplexer; DLAB swaps the divisor latches into indices 0 and 1.
   always_comb begin
      rdata8 = 8'h00;
      case (reg_idx)
         3'd0:    rdata8 = dlab ? dll : 8'h00;
         3'd1:    rdata8 = dlab ? dlm : ier;
         3'd2:    rdata8 = (ier[1] & thre) ? 8'h02 : 8'h01;
         3'd3:    rdata8 = lcr;
         3'd4:    rdata8 = mcr;
         3'd5:    rdata8 = lsr;
         3'd6:    rdata8 = 8'h00;
         3'd7:    rdata8 = scr;
         default: rdata8 = 8'h00;
      endcase
   end

   // Register writes commit on the edge that closes the access phase.
   // LSR and MSR are read-only; writes to them are silently ignored.
   always_ff @(posedge pclk or negedge preset) begin
      if (!preset) begin
         ier <= 8'h00;
         lcr <= 8'h03;
         mcr <= 8'h00;
         scr <= 8'h00;
         dll <= 8'h00;
         dlm <= 8'h00;
      end else if (wr_ok) begin
         case (reg_idx)
            3'd0:    if (dlab) dll <= wdata8;
            3'd1:    if (dlab) dlm <= wdata8; else ier <= wdata8;
            3'd3:    lcr <= wdata8;
            3'd4:    mcr <= wdata8;
            3'd7:    scr <= wdata8;
            default: ;
         endcase
      end
   end

   // FIFO data array; contents need no reset because the pointers gate them.
   always_ff @(posedge pclk) begin
      if (push) begin
         fifo_mem[wr_ptr[PTR_W-1:0]] <= wdata8;
      end
   end

   // FIFO pointers. A flush beats a same-cycle pop; the transmitter has
   // already latched the popped byte, so the frame in flight is unaffected.
   always_ff @(posedge pclk or negedge preset) begin
      if (!preset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (fsm_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   // Frame sequencer. A zero divisor freezes it completely (timer and line
   // hold), so a frame in flight simply stalls until D becomes non-zero.
   always_ff @(posedge pclk or negedge preset) begin
      if (!preset) begin
         state      <= ST_IDLE;
         tx_reg     <= 1'b1;
         bit_timer  <= 20'd0;
         shift_reg  <= 8'h00;
         bit_cnt    <= 3'd0;
         stop_cnt   <= 1'b0;
         f_last_bit <= 3'd7;
         f_stop2    <= 1'b0;
         f_par_en   <= 1'b0;
         f_par_bit  <= 1'b0;
      end else if (d_nz) begin
         case (state)
            ST_IDLE: ;
            ST_START: begin
               if (bit_done) begin
                  state     <= ST_DATA;
                  tx_reg    <= shift_reg[0];
                  shift_reg <= shift_reg >> 1;
                  bit_cnt   <= 3'd0;
                  bit_timer <= reload;
               end else begin
                  bit_timer <= bit_timer - 20'd1;
               end
            end
            ST_DATA: begin
               if (bit_done) begin
                  bit_timer <= reload;
                  if (bit_cnt == f_last_bit) begin
                     if (f_par_en) begin
                        state  <= ST_PARITY;
                        tx_reg <= f_par_bit;
                     end else begin
                        state    <= ST_STOP;
                        tx_reg   <= 1'b1;
                        stop_cnt <= 1'b0;
                     end
                  end else begin
                     bit_cnt   <= bit_cnt + 3'd1;
                     tx_reg    <= shift_reg[0];
                     shift_reg <= shift_reg >> 1;
                  end
               end else begin
                  bit_timer <= bit_timer - 20'd1;
               end
            end
            ST_PARITY: begin
               if (bit_done) begin
                  state     <= ST_STOP;
                  tx_reg    <= 1'b1;
                  stop_cnt  <= 1'b0;
                  bit_timer <= reload;
               end else begin
                  bit_timer <= bit_timer - 20'd1;
               end
            end
            ST_STOP: begin
               if (bit_done) begin
                  if (!last_stop) begin
                     stop_cnt  <= 1'b1;
                     bit_timer <= reload;
                  end else begin
                     state  <= ST_IDLE;
                     tx_reg <= 1'b1;
                  end
               end else begin
                  bit_timer <= bit_timer - 20'd1;
               end
            end
            default: begin
               state  <= ST_IDLE;
               tx_reg <= 1'b1;
            end
         endcase

         // Starting a frame overrides whatever the end of the stop bit chose.
         if (fsm_pop) begin
            state      <= ST_START;
            tx_reg     <= 1'b0;
            bit_timer  <= reload;
            shift_reg  <= fifo_rd_data;
            f_last_bit <= new_last_bit;
            f_stop2    <= lcr[2];
            f_par_en   <= lcr[3];
            f_par_bit  <= new_par_bit;
         end
      end
   end

   // Interrupt is the registered copy of IER[1] & THRE.
   always_ff @(posedge pclk or negedge preset) begin
      if (!preset) begin
         event_q <= 1'b0;
      end else begin
         event_q <= ier[1] & thre;
      end
   end

endmodule

// File: tb/tb_apb_uart_tx_slave.sv
// ---------------------------------------------------------------------------
// tb_apb_uart_tx_slave
// Directed bench for apb_uart_tx_slave: register reset values, frame formats,
// FIFO full/flush, interrupt, address errors, break and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_apb_uart_tx_slave;

   logic pclk;
   logic preset;
   logic tx_o;
   logic event_o;

   int checks;
   int failures;

   apb_uart_tx_slave_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus ();

   apb_uart_tx_slave #(
      .ADDR_WIDTH(12),
      .DATA_WIDTH(32),
      .FIFO_DEPTH(16)
   ) dut (
      .pclk    (pclk),
      .preset  (preset),
      .apb     (bus),
      .tx_o    (tx_o),
      .event_o (event_o)
   );

   // 10-unit clock period.
   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   // Hard time limit so a stuck bench still ends.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: time limit reached, got running expected finished");
      $fatal(1, "[TB] watchdog expired");
   end

   // APB write; err is pslverr sampled inside the access phase.
   // Returns 1 unit after the commit edge.
   task automatic apb_write(input logic [11:0] addr, input logic [31:0] data,
                            output logic err);
      @(posedge pclk); #1;
      bus.pselx   = 1'b1;
      bus.penable = 1'b0;
      bus.pwrite  = 1'b1;
      bus.paddr   = addr;
      bus.pwdata  = data;
      @(posedge pclk); #1;
      bus.penable = 1'b1;
      #1;
      err = bus.pslverr;
      @(posedge pclk); #1;
      bus.pselx   = 1'b0;
      bus.penable = 1'b0;
      bus.pwrite  = 1'b0;
   endtask

   // APB read; data, err and ready are sampled inside the access phase.
   task automatic apb_read(input logic [11:0] addr, output logic [31:0] data,
                           output logic err, output logic rdy);
      @(posedge pclk); #1;
      bus.pselx   = 1'b1;
      bus.penable = 1'b0;
      bus.pwrite  = 1'b0;
      bus.paddr   = addr;
      @(posedge pclk); #1;
      bus.penable = 1'b1;
      #1;
      data = bus.prdata;
      err  = bus.pslverr;
      rdy  = bus.pready;
      @(posedge pclk); #1;
      bus.pselx   = 1'b0;
      bus.penable = 1'b0;
   endtask

   // Waits (bounded) for the start bit, then samples nbits bit-centres at
   // 16 cycles per bit. wc = cycles until the line was first seen low.
   task automatic capture_frame(input int nbits, output logic [15:0] bits,
                                output bit ok, output int wc);
      bits = '1;
      ok   = 1'b0;
      wc   = 0;
      for (int i = 1; i <= 3000; i++) begin
         @(posedge pclk); #1;
         if (tx_o === 1'b0) begin
            ok = 1'b1;
            wc = i;
            break;
         end
      end
      if (ok) begin
         repeat (8) @(posedge pclk);
         #1;
         bits[0] = tx_o;
         for (int b = 1; b < nbits; b++) begin
            repeat (16) @(posedge pclk);
            #1;
            bits[b] = tx_o;
         end
      end
   endtask

   task automatic test_reset();
      logic [31:0] rd;
      logic        err;
      logic        rdy;
      checks++;
      if (tx_o !== 1'b1) begin
         failures++;
         $display("[TB] FAIL reset_tx: got %b expected 1", tx_o);
      end
      checks++;
      if (event_o !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_event: got %b expected 0", event_o);
      end
      checks++;
      if (bus.prdata !== 32'h0 || bus.pready !== 1'b0 || bus.pslverr !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_bus_idle: got prdata=%h pready=%b pslverr=%b expected 0/0/0",
                  bus.prdata, bus.pready, bus.pslverr);
      end
      apb_read(12'h014, rd, err, rdy);
      checks++;
      if (rd !== 32'h60 || err !== 1'b0 || rdy !== 1'b1) begin
         failures++;
         $display("[TB] FAIL reset_lsr: got %h err=%b rdy=%b expected 00000060 0 1", rd, err, rdy);
      end
      apb_read(12'h008, rd, err, rdy);
      checks++;
      if (rd !== 32'h01) begin
         failures++;
         $display("[TB] FAIL reset_iir: got %h expected 00000001", rd);
      end
      apb_read(12'h00C, rd, err, rdy);
      checks++;
      if (rd !== 32'h03) begin
         failures++;
         $display("[TB] FAIL reset_lcr: got %h expected 00000003", rd);
      end
   endtask

   task automatic test_frame_8n1();
      logic        err;
      logic [31:0] rd;
      logic        rdy;
      logic [15:0] bits;
      bit          ok;
      int          wc;
      apb_write(12'h00C, 32'h80, err);
      apb_write(12'h000, 32'h01, err);
      apb_write(12'h00C, 32'h03, err);
      apb_write(12'h000, 32'h55, err);
      checks++;
      if (tx_o !== 1'b1) begin
         failures++;
         $display("[TB] FAIL 8n1_pre_pop: got %b expected 1", tx_o);
      end
      capture_frame(10, bits, ok, wc);
      checks++;
      if (!ok || wc != 1) begin
         failures++;
         $display("[TB] FAIL 8n1_start_latency: got ok=%0d cycles=%0d expected 1 1", ok, wc);
      end
      checks++;
      if (bits[9:0] !== {1'b1, 8'h55, 1'b0}) begin
         failures++;
         $display("[TB] FAIL 8n1_frame: got %b expected %b", bits[9:0], {1'b1, 8'h55, 1'b0});
      end
      repeat (16) @(posedge pclk);
      apb_read(12'h014, rd, err, rdy);
      checks++;
      if (rd !== 32'h60) begin
         failures++;
         $display("[TB] FAIL 8n1_lsr_done: got %h expected 00000060", rd);
      end
   endtask

   task automatic test_frame_formats();
      logic        err;
      logic [31:0] rd;
      logic        rdy;
      logic [15:0] bits;
      bit          ok;
      int          wc;
      // 8 data, even parity, 1 stop
      apb_write(12'h00C, 32'h1B, err);
      apb_write(12'h000, 32'h07, err);
      capture_frame(11, bits, ok, wc);
      checks++;
      if (!ok || bits[10:0] !== {1'b1, 1'b1, 8'h07, 1'b0}) begin
         failures++;
         $display("[TB] FAIL 8e1_frame: got %b ok=%0d expected %b", bits[10:0], ok, {1'b1, 1'b1, 8'h07, 1'b0});
      end
      // 8 data, odd parity, 1 stop
      apb_write(12'h00C, 32'h0B, err);
      apb_write(12'h000, 32'h07, err);
      capture_frame(11, bits, ok, wc);
      checks++;
      if (!ok || bits[10:0] !== {1'b1, 1'b0, 8'h07, 1'b0}) begin
         failures++;
         $display("[TB] FAIL 8o1_frame: got %b ok=%0d expected %b", bits[10:0], ok, {1'b1, 1'b0, 8'h07, 1'b0});
      end
      repeat (16) @(posedge pclk);
      // 8 data, no parity, 2 stop: still busy during the second stop bit
      apb_write(12'h00C, 32'h07, err);
      apb_write(12'h000, 32'h07, err);
      capture_frame(11, bits, ok, wc);
      checks++;
      if (!ok || bits[10:0] !== {1'b1, 1'b1, 8'h07, 1'b0}) begin
         failures++;
         $display("[TB] FAIL 8n2_frame: got %b ok=%0d expected %b", bits[10:0], ok, {1'b1, 1'b1, 8'h07, 1'b0});
      end
      apb_read(12'h014, rd, err, rdy);
      checks++;
      if (rd !== 32'h20) begin
         failures++;
         $display("[TB] FAIL 8n2_second_stop_busy: got %h expected 00000020", rd);
      end
      repeat (20) @(posedge pclk);
      apb_read(12'h014, rd, err, rdy);
      checks++;
      if (rd !== 32'h60) begin
         failures++;
         $display("[TB] FAIL 8n2_lsr_done: got %h expected 00000060", rd);
      end
      // 5 data, no parity, 1 stop
      apb_write(12'h00C, 32'h00, err);
      apb_write(12'h000, 32'h13, err);
      capture_frame(7, bits, ok, wc);
      checks++;
      if (!ok || bits[6:0] !== 7'b1100110) begin
         failures++;
         $display("[TB] FAIL 5n1_frame: got %b ok=%0d expected 1100110", bits[6:0], ok);
      end
      repeat (20) @(posedge pclk);
      apb_write(12'h00C, 32'h03, err);
   endtask

   task automatic test_break();
      logic err;
      apb_write(12'h00C, 32'h43, err);
      checks++;
      if (tx_o !== 1'b0) begin
         failures++;
         $display("[TB] FAIL break_on: got %b expected 0", tx_o);
      end
      apb_write(12'h00C, 32'h03, err);
      checks++;
      if (tx_o !== 1'b1) begin
         failures++;
         $display("[TB] FAIL break_off: got %b expected 1", tx_o);
      end
   endtask

   task automatic test_back_to_back();
      logic        err;
      logic [31:0] rd;
      logic        rdy;
      logic [7:0]  d;
      logic        exp;
      int          errs;
      int          bad;
      int          f;
      int          p;
      apb_write(12'h00C, 32'h83, err);
      apb_write(12'h000, 32'h00, err);
      apb_write(12'h00C, 32'h03, err);
      errs = 0;
      for (int i = 0; i < 16; i++) begin
         apb_write(12'h000, 32'h30 + i, err);
         if (err !== 1'b0) errs++;
      end
      checks++;
      if (errs != 0) begin
         failures++;
         $display("[TB] FAIL fifo_fill_err: got %0d errors expected 0", errs);
      end
      apb_write(12'h000, 32'hEE, err);
      checks++;
      if (err !== 1'b1) begin
         failures++;
         $display("[TB] FAIL fifo_17th_pslverr: got %b expected 1", err);
      end
      apb_read(12'h014, rd, err, rdy);
      checks++;
      if (rd !== 32'h00) begin
         failures++;
         $display("[TB] FAIL fifo_full_lsr: got %h expected 00000000", rd);
      end
      // LCR stays 0x83 (8N1 with DLAB) while the 16 frames drain.
      apb_write(12'h00C, 32'h83, err);
      apb_write(12'h000, 32'h01, err);
      bad = 0;
      for (int c = 0; c < 2560; c++) begin
         @(posedge pclk); #1;
         f = c / 160;
         p = (c % 160) / 16;
         d = 8'h30 + f[7:0];
         if (p == 0)      exp = 1'b0;
         else if (p == 9) exp = 1'b1;
         else             exp = d[p-1];
         if (tx_o !== exp) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("[TB] FAIL b2b_stream: got %0d wrong cycles expected 0", bad);
      end
      bad = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge pclk); #1;
         if (tx_o !== 1'b1) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("[TB] FAIL b2b_no_17th_frame: got %0d low cycles expected 0", bad);
      end
      apb_read(12'h014, rd, err, rdy);
      checks++;
      if (rd !== 32'h60) begin
         failures++;
         $display("[TB] FAIL b2b_lsr_done: got %h expected 00000060", rd);
      end
      apb_write(12'h00C, 32'h03, err);
   endtask

   task automatic test_interrupt();
      logic        err;
      logic [31:0] rd;
      logic        rdy;
      apb_write(12'h00C, 32'h83, err);
      apb_write(12'h000, 32'h00, err);
      apb_write(12'h00C, 32'h03, err);
      checks++;
      if (event_o !== 1'b0) begin
         failures++;
         $display("[TB] FAIL irq_masked: got %b expected 0", event_o);
      end
      apb_write(12'h004, 32'h02, err);
      @(posedge pclk); #1;
      checks++;
      if (event_o !== 1'b1) begin
         failures++;
         $display("[TB] FAIL irq_enable: got %b expected 1", event_o);
      end
      apb_read(12'h008, rd, err, rdy);
      checks++;
      if (rd !== 32'h02) begin
         failures++;
         $display("[TB] FAIL irq_iir_pending: got %h expected 00000002", rd);
      end
      apb_write(12'h000, 32'hA5, err);
      repeat (2) @(posedge pclk);
      #1;
      checks++;
      if (event_o !== 1'b0) begin
         failures++;
         $display("[TB] FAIL irq_clear_on_push: got %b expected 0", event_o);
      end
      apb_read(12'h008, rd, err, rdy);
      checks++;
      if (rd !== 32'h01) begin
         failures++;
         $display("[TB] FAIL irq_iir_none: got %h expected 00000001", rd);
      end
      apb_write(12'h00C, 32'h83, err);
      apb_write(12'h000, 32'h01, err);
      repeat (2) @(posedge pclk);
      #1;
      checks++;
      if (event_o !== 1'b1) begin
         failures++;
         $display("[TB] FAIL irq_after_pop: got %b expected 1", event_o);
      end
      apb_read(12'h008, rd, err, rdy);
      checks++;
      if (rd !== 32'h02) begin
         failures++;
         $display("[TB] FAIL irq_iir_after_pop: got %h expected 00000002", rd);
      end
      apb_read(12'h014, rd, err, rdy);
      checks++;
      if (rd !== 32'h20) begin
         failures++;
         $display("[TB] FAIL irq_lsr_in_flight: got %h expected 00000020", rd);
      end
      apb_write(12'h00C, 32'h03, err);
      repeat (200) @(posedge pclk);
      apb_write(12'h004, 32'h00, err);
      repeat (2) @(posedge pclk);
      #1;
      checks++;
      if (event_o !== 1'b0) begin
         failures++;
         $display("[TB] FAIL irq_disable: got %b expected 0", event_o);
      end
   endtask

   task automatic test_flush();
      logic        err;
      logic [31:0] rd;
      logic        rdy;
      apb_write(12'h00C, 32'h83, err);
      apb_write(12'h000, 32'h00, err);
      apb_write(12'h00C, 32'h03, err);
      for (int i = 0; i < 3; i++) begin
         apb_write(12'h000, 32'hC0 + i, err);
      end
      apb_read(12'h014, rd, err, rdy);
      checks++;
      if (rd !== 32'h00) begin
         failures++;
         $display("[TB] FAIL flush_pre_lsr: got %h expected 00000000", rd);
      end
      apb_write(12'h008, 32'h03, err);
      apb_read(12'h014, rd, err, rdy);
      checks++;
      if (rd !== 32'h00) begin
         failures++;
         $display("[TB] FAIL fcr_no_flush_bit: got %h expected 00000000", rd);
      end
      apb_write(12'h008, 32'h04, err);
      apb_read(12'h014, rd, err, rdy);
      checks++;
      if (rd !== 32'h60) begin
         failures++;
         $display("[TB] FAIL flush_lsr: got %h expected 00000060", rd);
      end
   endtask

   task automatic test_addr_error();
      logic        err;
      logic [31:0] rd;
      logic        rdy;
      apb_write(12'h020, 32'h41, err);
      checks++;
      if (err !== 1'b1) begin
         failures++;
         $display("[TB] FAIL addr_err_write: got %b expected 1", err);
      end
      apb_read(12'h014, rd, err, rdy);
      checks++;
      if (rd !== 32'h60) begin
         failures++;
         $display("[TB] FAIL addr_err_no_push: got %h expected 00000060", rd);
      end
      apb_write(12'h02C, 32'h00, err);
      apb_read(12'h00C, rd, err, rdy);
      checks++;
      if (rd !== 32'h03) begin
         failures++;
         $display("[TB] FAIL addr_err_lcr_kept: got %h expected 00000003", rd);
      end
      apb_read(12'h034, rd, err, rdy);
      checks++;
      if (err !== 1'b1 || rd !== 32'h0 || rdy !== 1'b1) begin
         failures++;
         $display("[TB] FAIL addr_err_read: got err=%b data=%h rdy=%b expected 1 00000000 1", err, rd, rdy);
      end
      apb_write(12'h01C, 32'hFFFFFF5A, err);
      checks++;
      if (err !== 1'b0) begin
         failures++;
         $display("[TB] FAIL scr_write_err: got %b expected 0", err);
      end
      apb_read(12'h01C, rd, err, rdy);
      checks++;
      if (rd !== 32'h5A) begin
         failures++;
         $display("[TB] FAIL scr_readback: got %h expected 0000005a", rd);
      end
      apb_write(12'h014, 32'hFF, err);
      checks++;
      if (err !== 1'b0) begin
         failures++;
         $display("[TB] FAIL lsr_write_err: got %b expected 0", err);
      end
      apb_read(12'h014, rd, err, rdy);
      checks++;
      if (rd !== 32'h60) begin
         failures++;
         $display("[TB] FAIL lsr_write_ignored: got %h expected 00000060", rd);
      end
      apb_read(12'h018, rd, err, rdy);
      checks++;
      if (rd !== 32'h0) begin
         failures++;
         $display("[TB] FAIL msr_zero: got %h expected 00000000", rd);
      end
   endtask

   task automatic test_reset_mid_frame();
      logic        err;
      logic [31:0] rd;
      logic        rdy;
      apb_write(12'h00C, 32'h83, err);
      apb_write(12'h000, 32'h01, err);
      apb_write(12'h00C, 32'h03, err);
      apb_write(12'h000, 32'h00, err);
      apb_write(12'h000, 32'h00, err);
      repeat (40) @(posedge pclk);
      #1;
      checks++;
      if (tx_o !== 1'b0) begin
         failures++;
         $display("[TB] FAIL mid_frame_low: got %b expected 0", tx_o);
      end
      #3;
      preset = 1'b0;
      #1;
      checks++;
      if (tx_o !== 1'b1) begin
         failures++;
         $display("[TB] FAIL async_reset_tx: got %b expected 1", tx_o);
      end
      repeat (2) @(posedge pclk);
      @(negedge pclk);
      preset = 1'b1;
      apb_read(12'h014, rd, err, rdy);
      checks++;
      if (rd !== 32'h60) begin
         failures++;
         $display("[TB] FAIL post_reset_lsr: got %h expected 00000060", rd);
      end
      apb_write(12'h00C, 32'h83, err);
      apb_read(12'h000, rd, err, rdy);
      checks++;
      if (rd !== 32'h00) begin
         failures++;
         $display("[TB] FAIL post_reset_dll: got %h expected 00000000", rd);
      end
      apb_write(12'h00C, 32'h03, err);
      checks++;
      if (tx_o !== 1'b1 || event_o !== 1'b0) begin
         failures++;
         $display("[TB] FAIL post_reset_lines: got tx=%b event=%b expected 1 0", tx_o, event_o);
      end
   endtask

   initial begin
      checks      = 0;
      failures    = 0;
      preset      = 1'b0;
      bus.pselx   = 1'b0;
      bus.penable = 1'b0;
      bus.pwrite  = 1'b0;
      bus.paddr   = '0;
      bus.pwdata  = '0;
      repeat (3) @(posedge pclk);
      @(negedge pclk);
      preset = 1'b1;
      repeat (2) @(posedge pclk);
      #1;

      test_reset();
      test_frame_8n1();
      test_frame_formats();
      test_break();
      test_back_to_back();
      test_interrupt();
      test_flush();
      test_addr_error();
      test_reset_mid_frame();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
